pipe_hazard_sb: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage pipeline computer. It replaces the purely combinational stall/forward logic in the control unit.
It keeps the EXE/MEM forwarding and load-use stall. It adds a per-register scoreboard for variable-latency long ops (mul/div unit), an outstanding-op limit, WAW protection, a saturating stall counter and a sticky protocol-error flag.
It sits beside the ID stage. Its outputs drive the PC/IF-ID write enables, the ID-to-EXE bubble insertion and the operand-forwarding muxes.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/hazard_scoreboard.sv | 54 +++++
 rtl/pipe_hazard_sb.sv | 90 +++++++++
 tb/tb_pipe_hazard_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forward-select codes and default register-file geometry
package pipe_pkg;
    localparam int DEF_NREG = 32;
    localparam int DEF_RW   = 5;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMEM = 2'b11;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy bits and outstanding-op count for the long unit
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG       = DEF_NREG,
    parameter int RW         = DEF_RW,
    parameter int LONG_DEPTH = 2
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            issue,
    input  logic [RW-1:0]   issue_rn,
    input  logic            done,
    input  logic [RW-1:0]   done_rn,
    output logic [NREG-1:0] busy,
    output logic            full,
    output logic            err
);
    localparam int OW = 3;
    logic [NREG-1:0] busy_q, busy_d;
    logic [OW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            done_busy;
    // next busy/count/error: completion clears first so a same-register issue wins
    always_comb begin
        busy_d    = busy_q;
        done_busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (done && done_rn == RW'(r)) begin
                busy_d[r] = 1'b0;
                done_busy = busy_q[r];
            end
            if (issue && issue_rn == RW'(r)) busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d = cnt_q + OW'(issue) - OW'(done && cnt_q != '0);
        err_d = err_q | (done & (cnt_q == '0)) | (done & (done_rn != '0) & ~done_busy);
    end
    // scoreboard state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
    assign busy = busy_q;
    assign full = cnt_q == OW'(LONG_DEPTH);
    assign err  = err_q;
endmodule

// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb: ID-stage stall/forward control with long-op scoreboard and stall counter
module pipe_hazard_sb
    import pipe_pkg::*;
#(
    parameter int NREG       = DEF_NREG,
    parameter int RW         = DEF_RW,
    parameter int LONG_DEPTH = 2,
    parameter int SCW        = 16
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wreg,
    input  logic [RW-1:0]   id_rn,
    input  logic            id_long,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic [RW-1:0]   ern,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [RW-1:0]   mrn,
    input  logic            lu_done,
    input  logic [RW-1:0]   lu_rn,
    output logic            wpcir,
    output logic            bubble,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic [NREG-1:0] sb_busy,
    output logic [SCW-1:0]  stall_cnt,
    output logic            sb_err
);
    logic           rd_a, rd_b, busy_a, busy_b, busy_w;
    logic           load_stall, sb_stall, full, full_stall, issue;
    logic [RW-1:0]  issue_rn;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
        if (src == '0) return FWD_RF;
        if (ewreg && ern == src && !em2reg) return FWD_EALU;
        if (mwreg && mrn == src) return mm2reg ? FWD_MMEM : FWD_MALU;
        return FWD_RF;
    endfunction

    hazard_scoreboard #(.NREG(NREG), .RW(RW), .LONG_DEPTH(LONG_DEPTH)) u_sb (
        .clock    (clock),
        .resetn   (resetn),
        .issue    (issue),
        .issue_rn (issue_rn),
        .done     (lu_done),
        .done_rn  (lu_rn),
        .busy     (sb_busy),
        .full     (full),
        .err      (sb_err)
    );

    // stall sources and forwarding; reset forces advance with register-file operands
    always_comb begin
        rd_a   = id_use_rs && id_rs != '0;
        rd_b   = id_use_rt && id_rt != '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        busy_w = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy_a = busy_a | (sb_busy[r] && id_rs == RW'(r));
            busy_b = busy_b | (sb_busy[r] && id_rt == RW'(r));
            busy_w = busy_w | (sb_busy[r] && id_rn == RW'(r));
        end
        load_stall = ewreg && em2reg && ern != '0 && ((rd_a && ern == id_rs) || (rd_b && ern == id_rt));
        sb_stall   = (rd_a && busy_a) || (rd_b && busy_b) || (id_wreg && id_rn != '0 && busy_w);
        full_stall = id_long && full && !lu_done;
        wpcir      = !resetn || !(load_stall || sb_stall || full_stall);
        bubble     = !wpcir;
        fwda       = resetn ? fwd_sel(id_rs) : FWD_RF;
        fwdb       = resetn ? fwd_sel(id_rt) : FWD_RF;
        issue      = resetn && wpcir && id_long;
        issue_rn   = id_wreg ? id_rn : '0;
        stall_cnt_d = (!wpcir && !(&stall_cnt_q)) ? stall_cnt_q + SCW'(1) : stall_cnt_q;
    end

    // saturating count of stalled cycles
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_sb.sv
// tb_pipe_hazard_sb: directed checks of stall, forwarding, scoreboard and counter behaviour
module tb_pipe_hazard_sb;
    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs, id_rt, id_rn, ern, mrn, lu_rn;
    logic        id_use_rs, id_use_rt, id_wreg, id_long;
    logic        ewreg, em2reg, mwreg, mm2reg, lu_done;
    logic        wpcir, bubble, sb_err;
    logic [1:0]  fwda, fwdb;
    logic [31:0] sb_busy;
    logic [3:0]  stall_cnt;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_sb #(.NREG(32), .RW(5), .LONG_DEPTH(2), .SCW(4)) dut (
        .clock(clock), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_rn(id_rn), .id_long(id_long),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .lu_done(lu_done), .lu_rn(lu_rn),
        .wpcir(wpcir), .bubble(bubble), .fwda(fwda), .fwdb(fwdb),
        .sb_busy(sb_busy), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    task automatic idle();
        {id_rs, id_rt, id_rn, ern, mrn, lu_rn} = '0;
        {id_use_rs, id_use_rt, id_wreg, id_long} = '0;
        {ewreg, em2reg, mwreg, mm2reg, lu_done} = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        #3;
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", sb_busy); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        checks++; if (wpcir !== 1'b1 || bubble !== 1'b0) begin errors++; $display("FAIL reset_wpcir got %b/%b exp 1/0", wpcir, bubble); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", sb_err); end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_load_use();
        idle();
        ewreg = 1; em2reg = 1; ern = 3; id_use_rs = 1; id_rs = 3;
        #1;
        checks++; if (wpcir !== 1'b0 || bubble !== 1'b1) begin errors++; $display("FAIL load_stall got %b/%b exp 0/1", wpcir, bubble); end
        tick();
        ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 3;
        #1;
        checks++; if (fwda !== 2'b11) begin errors++; $display("FAIL load_fwd got %b exp 11", fwda); end
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL load_release got %b exp 1", wpcir); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL load_cnt got %0d exp 1", stall_cnt); end
        tick();
    endtask

    task automatic test_fwd_priority();
        idle();
        ewreg = 1; mwreg = 1; ern = 4; mrn = 4; id_use_rt = 1; id_rt = 4;
        #1;
        checks++; if (fwdb !== 2'b01) begin errors++; $display("FAIL fwd_exe got %b exp 01", fwdb); end
        ern = 0;
        #1;
        checks++; if (fwdb !== 2'b10) begin errors++; $display("FAIL fwd_mem got %b exp 10", fwdb); end
        ern = 4; em2reg = 1;
        #1;
        checks++; if (fwdb !== 2'b10) begin errors++; $display("FAIL fwd_skip_load got %b exp 10", fwdb); end
        em2reg = 0; ern = 0; mrn = 0; id_rt = 0;
        #1;
        checks++; if (fwdb !== 2'b00) begin errors++; $display("FAIL fwd_r0 got %b exp 00", fwdb); end
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL fwda_idle got %b exp 00", fwda); end
    endtask

    task automatic test_raw();
        idle();
        id_long = 1; id_wreg = 1; id_rn = 8;
        #1;
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL raw_issue got %b exp 1", wpcir); end
        tick();
        idle();
        checks++; if (sb_busy[8] !== 1'b1) begin errors++; $display("FAIL raw_busy got %b exp 1", sb_busy[8]); end
        id_use_rs = 1; id_rs = 8;
        #1;
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", wpcir); end
        tick();
        lu_done = 1; lu_rn = 8;
        #1;
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL raw_done_same got %b exp 0", wpcir); end
        tick();
        lu_done = 0; lu_rn = 0;
        #1;
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", wpcir); end
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL raw_clear got %h exp 0", sb_busy); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL raw_err got %b exp 0", sb_err); end
    endtask

    task automatic test_depth();
        idle();
        id_long = 1; id_wreg = 1; id_rn = 9;
        tick();
        id_rn = 10;
        tick();
        checks++; if (sb_busy[10:9] !== 2'b11) begin errors++; $display("FAIL depth_busy got %b exp 11", sb_busy[10:9]); end
        id_rn = 11;
        #1;
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL depth_full got %b exp 0", wpcir); end
        lu_done = 1; lu_rn = 9;
        #1;
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL depth_slot got %b exp 1", wpcir); end
        tick();
        lu_done = 0; lu_rn = 0; id_rn = 12;
        #1;
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL depth_still_full got %b exp 0", wpcir); end
        checks++; if (sb_busy[12:9] !== 4'b0110) begin errors++; $display("FAIL depth_vec got %b exp 0110", sb_busy[12:9]); end
        id_long = 0; id_rn = 10;
        #1;
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", wpcir); end
        id_rn = 9;
        #1;
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL waw_free got %b exp 1", wpcir); end
        idle();
        lu_done = 1; lu_rn = 10;
        tick();
        lu_rn = 11;
        tick();
        idle();
        #1;
        checks++; if (sb_busy !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL depth_drain got %h/%b exp 0/0", sb_busy, sb_err); end
    endtask

    task automatic test_errors();
        idle();
        lu_done = 1;
        tick();
        idle();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", sb_err); end
        tick();
        tick();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", sb_err); end
        id_long = 1; id_wreg = 1; id_rn = 1;
        tick();
        id_rn = 2;
        tick();
        id_rn = 3;
        #1;
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL err_cnt_floor got %b exp 0", wpcir); end
        idle();
        lu_done = 1; lu_rn = 6;
        tick();
        idle();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_still got %b exp 1", sb_err); end
    endtask

    task automatic test_reset_mid_run();
        idle();
        resetn = 0;
        #1;
        resetn = 1;
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL mid_pre_err got %b exp 0", sb_err); end
        id_long = 1; id_wreg = 1; id_rn = 5;
        tick();
        idle();
        ewreg = 1; em2reg = 1; ern = 3; id_use_rs = 1; id_rs = 3; mwreg = 1; mrn = 3;
        repeat (7) tick();
        checks++; if (stall_cnt !== 4'd7 || sb_busy[5] !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b exp 7/1", stall_cnt, sb_busy[5]); end
        checks++; if (fwda !== 2'b10 || wpcir !== 1'b0) begin errors++; $display("FAIL mid_active got %b/%b exp 10/0", fwda, wpcir); end
        #2;
        resetn = 0;
        #1;
        checks++; if (sb_busy !== 32'h0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset_state got %h/%0d exp 0/0", sb_busy, stall_cnt); end
        checks++; if (wpcir !== 1'b1 || bubble !== 1'b0 || fwda !== 2'b00) begin errors++; $display("FAIL mid_reset_out got %b/%b/%b exp 1/0/00", wpcir, bubble, fwda); end
        tick();
        resetn = 1;
    endtask

    task automatic test_saturation();
        repeat (20) tick();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cnt); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_raw();
        test_depth();
        test_errors();
        test_reset_mid_run();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
